// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - address map, state encoding and decode helpers for mio_bus_ctrl
package mio_pkg;

  // Region nibbles, taken from addr_bus[31:28]
  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_LED = 4'hE;
  localparam logic [3:0] REG_SYS = 4'hF;

  // Register offsets inside a region (byte offsets, word aligned)
  localparam logic [27:0] OFF_LED = 28'h0;
  localparam logic [27:0] OFF_SW  = 28'h0;
  localparam logic [27:0] OFF_CNT = 28'h4;

  // The RAM wait counter is three bits wide
  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_RD,
    ST_RAM_WR,
    ST_IO,
    ST_DONE
  } state_t;

  // What a request targets once the address and direction are decoded
  typedef enum logic [2:0] {
    ACC_RAM,
    ACC_LED,
    ACC_SW,
    ACC_CNT,
    ACC_BAD
  } acc_t;

  function automatic bit ram_lat_ok(input int lat);
    return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
  endfunction

  // Word-granular decode: the byte-lane bits never reach this function.
  // Read and write together is never a legal access.
  function automatic acc_t decode(input logic [31:2] a, input logic rd, input logic wr);
    logic [27:0] off;
    acc_t        kind;
    off  = {a[27:2], 2'b00};
    kind = ACC_BAD;
    if (rd != wr) begin
      case (a[31:28])
        REG_RAM: kind = ACC_RAM;
        REG_LED: begin
          if (off == OFF_LED) kind = ACC_LED;
        end
        REG_SYS: begin
          if (off == OFF_SW && rd) kind = ACC_SW;
          else if (off == OFF_CNT) kind = ACC_CNT;
        end
        default: kind = ACC_BAD;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/mio_cycle_counter.sv
// rtl/mio_cycle_counter.sv - free-running wrapping cycle counter with synchronous clear
module mio_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count every cycle; a clear loads zero on its edge and counting resumes next cycle
  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else              count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// rtl/mio_bus_ctrl.sv - CPU memory/IO bus controller: RAM wait states, LED, switches, cycle counter
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic              cpu_mio,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       data_from_cpu,
  output logic [31:0]       data_to_cpu,
  output logic              mio_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic [7:0]        led_out,
  input  logic [15:0]       sw_in
);

  if (!ram_lat_ok(RAM_LAT)) begin : g_lat_check
    $error("mio_bus_ctrl: RAM_LAT must be within 1..7");
  end

  state_t           state, state_nxt;
  logic [2:0]       wait_cnt;
  logic [31:2]      req_addr;
  logic             req_rd, req_wr;
  logic [7:0]       req_led;
  logic [CNT_W-1:0] cnt;
  acc_t             new_acc, cur_acc;
  logic             req_valid, accept, rd_capture, io_step, ready_nxt, cnt_clr;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^addr_bus[1:0];
  assign req_valid       = cpu_mio & (mem_r | mem_w);
  // new_acc decodes the live bus at accept; cur_acc decodes the latched request,
  // so a CPU that drops its request mid-transaction cannot disturb completion.
  assign new_acc         = decode(addr_bus[31:2], mem_r, mem_w);
  assign cur_acc         = decode(req_addr, req_rd, req_wr);

  mio_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .count(cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: RAM writes finish through IO so ready lands one cycle after the write strobe
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (new_acc == ACC_RAM) state_nxt = mem_r ? ST_RAM_RD : ST_RAM_WR;
          else                    state_nxt = ST_IO;
        end
      end
      ST_RAM_RD: if (wait_cnt == 3'd0) state_nxt = ST_DONE;
      ST_RAM_WR: state_nxt = ST_IO;
      ST_IO:     state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept     = (state == ST_IDLE) && req_valid;
    ram_we     = (state == ST_RAM_WR);
    rd_capture = (state == ST_RAM_RD) && (wait_cnt == 3'd0);
    io_step    = (state == ST_IO);
    ready_nxt  = rd_capture || io_step;
    cnt_clr    = io_step && (cur_acc == ACC_CNT) && req_wr;
  end

  // Request latch, RAM interface, peripheral registers and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      req_addr    <= '0;
      req_rd      <= 1'b0;
      req_wr      <= 1'b0;
      req_led     <= '0;
      ram_addr    <= '0;
      ram_din     <= '0;
      mio_ready   <= 1'b0;
      data_to_cpu <= '0;
      led_out     <= '0;
      bus_err     <= 1'b0;
    end else begin
      mio_ready <= ready_nxt;
      if (accept) begin
        req_addr <= addr_bus[31:2];
        req_rd   <= mem_r;
        req_wr   <= mem_w;
        req_led  <= data_from_cpu[7:0];
        wait_cnt <= 3'(RAM_LAT);
        if (new_acc == ACC_RAM) begin
          ram_addr <= addr_bus[RAM_AW+1:2];
          if (mem_w) ram_din <= data_from_cpu;
        end
      end
      if (state == ST_RAM_RD && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
      if (rd_capture) data_to_cpu <= ram_dout;
      if (io_step) begin
        case (cur_acc)
          ACC_LED: begin
            if (req_wr) led_out     <= req_led;
            else        data_to_cpu <= {24'h0, led_out};
          end
          ACC_SW:  data_to_cpu <= {16'h0, sw_in};
          ACC_CNT: if (req_rd) data_to_cpu <= 32'(cnt);
          ACC_BAD: begin
            bus_err <= 1'b1;
            if (req_rd) data_to_cpu <= '0;
          end
          default: ;  // tail of a RAM write: nothing left to do but signal ready
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb/tb_mio_bus_ctrl.sv - scoreboard bench for mio_bus_ctrl with a behavioural bus model
module tb_mio_bus_ctrl;
  localparam int AW  = 10;
  localparam int LAT = 1;
  localparam int NW  = 1 << AW;

  logic          clk, reset, mem_r, mem_w, cpu_mio;
  logic [31:0]   addr_bus, data_from_cpu, data_to_cpu, ram_din, ram_dout;
  logic          mio_ready, bus_err, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    led_out;
  logic [15:0]   sw_in;

  logic          reset3, mem_r3, mem_w3, cpu_mio3, mio_ready3, bus_err3, ram_we3;
  logic [31:0]   addr3, wdata3, rdata3, ram_din3, ram_dout3;
  logic [AW-1:0] ram_addr3;
  logic [7:0]    led3;

  typedef struct {
    int            acc;
    int            lat;
    logic [31:0]   data;
    logic [7:0]    led;
    bit            err;
    int            we;
    logic [AW-1:0] we_addr;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  int            rdy_cnt = 0;
  int            we_n = 0;
  logic [AW-1:0] we_addr;
  bit            prev_rdy = 0;

  logic [31:0]   mm[NW];
  logic [31:0]   env_mem[NW];
  logic [31:0]   rd_q;
  logic [7:0]    m_led;
  bit            m_err;
  logic [31:0]   m_data;
  int            clr_edge;

  mio_bus_ctrl #(.RAM_AW(AW), .RAM_LAT(LAT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .cpu_mio(cpu_mio),
    .addr_bus(addr_bus), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .mio_ready(mio_ready), .bus_err(bus_err), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .led_out(led_out), .sw_in(sw_in)
  );

  mio_bus_ctrl #(.RAM_AW(AW), .RAM_LAT(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset3), .mem_r(mem_r3), .mem_w(mem_w3), .cpu_mio(cpu_mio3),
    .addr_bus(addr3), .data_from_cpu(wdata3), .data_to_cpu(rdata3),
    .mio_ready(mio_ready3), .bus_err(bus_err3), .ram_addr(ram_addr3), .ram_we(ram_we3),
    .ram_din(ram_din3), .ram_dout(ram_dout3), .led_out(led3), .sw_in(sw_in)
  );

  assign ram_dout3 = 32'h0BAD_F00D;
  assign ram_dout  = rd_q;

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Block RAM with one cycle of read latency, preloaded from the model image during reset
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) env_mem[i] <= mm[i];
    end else if (ram_we) begin
      env_mem[ram_addr] <= ram_din;
    end
    rd_q <= env_mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every ready pulse
  always begin
    @(posedge clk);
    #1;
    if (ram_we) begin
      we_n++;
      we_addr = ram_addr;
    end
    if (mio_ready) begin
      rdy_cnt++;
      chk("ready_back_to_back", 32'(prev_rdy), 0);
      chk("ready_has_request", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("latency", cyc - mon_e.acc, mon_e.lat);
        chk("data_to_cpu", data_to_cpu, mon_e.data);
        chk("led_out", 32'(led_out), 32'(mon_e.led));
        chk("bus_err", 32'(bus_err), 32'(mon_e.err));
        chk("ram_we_pulses", we_n, mon_e.we);
        if (mon_e.we == 1) chk("ram_we_addr", 32'(we_addr), 32'(mon_e.we_addr));
      end
      we_n = 0;
    end
    prev_rdy = mio_ready;
  end

  // One CPU access: model the expected outcome, drive the request, hold it until one
  // cycle after ready (optionally dropping it right after acceptance)
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input bit early_drop);
    exp_t        e;
    int          start;
    bit          got;
    logic [3:0]  rg;
    logic [27:0] off;
    int          word;
    rg   = a[31:28];
    off  = a[27:0] & ~28'h3;
    word = int'(a[AW+1:2]);
    e.acc = cyc + 1;
    e.lat = 1;
    e.we = 0;
    e.we_addr = '0;
    if (rd && wr) begin
      m_err = 1;
      m_data = 0;
    end else if (rg == 4'h0) begin
      if (rd) begin
        e.lat = LAT + 1;
        m_data = mm[word];
      end else begin
        e.lat = 2;
        mm[word] = d;
        e.we = 1;
        e.we_addr = a[AW+1:2];
      end
    end else if (rg == 4'hE && off == 0) begin
      if (wr) m_led = d[7:0];
      else    m_data = {24'h0, m_led};
    end else if (rg == 4'hF && off == 0 && rd) begin
      m_data = {16'h0, sw_in};
    end else if (rg == 4'hF && off == 4) begin
      if (rd) m_data = e.acc - clr_edge;
      else    clr_edge = e.acc + 1;
    end else begin
      m_err = 1;
      if (rd) m_data = 0;
    end
    e.data = m_data;
    e.led = m_led;
    e.err = m_err;
    q.push_back(e);
    mem_r = rd; mem_w = wr; addr_bus = a; data_from_cpu = d; cpu_mio = 1;
    start = rdy_cnt;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (early_drop) begin
        mem_r = 0; mem_w = 0; cpu_mio = 0;
      end
      if (rdy_cnt != start) begin
        got = 1;
        break;
      end
    end
    chk("ready_seen", 32'(got), 1);
    if (!got) q.delete();
    @(negedge clk);
    mem_r = 0; mem_w = 0; cpu_mio = 0;
  endtask

  // Idle cycles with junk on the bus but no cpu_mio qualifier
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      mem_r = 1'($urandom); mem_w = 1'($urandom); cpu_mio = 0;
      addr_bus = $urandom; data_from_cpu = $urandom;
      @(negedge clk);
    end
    mem_r = 0; mem_w = 0; cpu_mio = 0;
  endtask

  task automatic io3(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     output int lat);
    int c0;
    c0 = cyc;
    lat = -1;
    mem_r3 = rd; mem_w3 = wr; addr3 = a; wdata3 = d; cpu_mio3 = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mio_ready3) begin
        lat = cyc - c0;
        break;
      end
    end
    @(negedge clk);
    mem_r3 = 0; mem_w3 = 0; cpu_mio3 = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          l3;
    bit          seen3;
    logic [31:0] r32, d32;
    int          k;
    bit          ed;
    reset = 1; reset3 = 1;
    mem_r = 0; mem_w = 0; cpu_mio = 0; addr_bus = 0; data_from_cpu = 0; sw_in = 0;
    mem_r3 = 0; mem_w3 = 0; cpu_mio3 = 0; addr3 = 0; wdata3 = 0;
    for (int i = 0; i < NW; i++) mm[i] = $urandom;
    mm[4] = 32'hDEADBEEF;
    m_led = 0; m_err = 0; m_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_mio_ready", 32'(mio_ready), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_led_out", 32'(led_out), 0);
    chk("rst_data_to_cpu", data_to_cpu, 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_din", ram_din, 0);
    reset = 0; reset3 = 0;
    clr_edge = cyc;

    txn(1, 0, 32'h0000_0010, 0, 0);
    txn(0, 1, 32'h0000_0008, 32'h1234_5678, 0);
    txn(1, 0, 32'h0000_0008, 0, 0);
    txn(0, 1, 32'hE000_0000, 32'h0000_00A5, 0);
    txn(1, 0, 32'hE000_0000, 0, 0);
    sw_in = 16'hBEEF;
    txn(1, 0, 32'hF000_0000, 0, 0);
    txn(0, 1, 32'hF000_0004, 0, 0);
    gap(10);
    txn(1, 0, 32'hF000_0004, 0, 0);
    txn(1, 0, 32'h3000_0000, 0, 0);
    txn(1, 1, 32'h0000_0020, 32'h55, 0);
    txn(1, 0, 32'hE000_0000, 0, 0);

    io3(0, 1, 32'hE000_0000, 32'h5A, l3);
    chk("l3_led_wr_latency", l3, 2);
    io3(1, 0, 32'hE000_0000, 0, l3);
    chk("l3_led_rd_latency", l3, 2);
    chk("l3_led_rd_data", rdata3, 32'h5A);
    addr3 = 32'h0000_0040; mem_r3 = 1; cpu_mio3 = 1;
    @(negedge clk);
    chk("l3_ram_addr", 32'(ram_addr3), 16);
    @(negedge clk);
    reset3 = 1; mem_r3 = 0; cpu_mio3 = 0;
    @(negedge clk);
    chk("l3_rst_mio_ready", 32'(mio_ready3), 0);
    chk("l3_rst_ram_we", 32'(ram_we3), 0);
    chk("l3_rst_data", rdata3, 0);
    chk("l3_rst_ram_addr", 32'(ram_addr3), 0);
    chk("l3_rst_ram_din", ram_din3, 0);
    chk("l3_rst_led", 32'(led3), 0);
    chk("l3_rst_bus_err", 32'(bus_err3), 0);
    reset3 = 0;
    seen3 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mio_ready3) seen3 = 1;
    end
    chk("l3_no_ready_after_abort", 32'(seen3), 0);
    io3(1, 0, 32'hE000_0000, 0, l3);
    chk("l3_idle_after_reset", l3, 2);
    chk("l3_led_after_reset", rdata3, 0);

    for (int n = 0; n < 60; n++) begin
      k   = $urandom_range(0, 7);
      r32 = $urandom;
      d32 = $urandom;
      ed  = ($urandom_range(0, 3) == 0);
      case (k)
        0, 1: txn(1, 0, {4'h0, r32[27:0]}, 0, ed);
        2, 3: txn(0, 1, {4'h0, r32[27:0]}, d32, ed);
        4:    txn(r32[0], ~r32[0], {4'hE, 26'h0, r32[2:1]}, d32, 0);
        5: begin
          sw_in = d32[15:0];
          txn(1, 0, {4'hF, 26'h0, r32[2:1]}, 0, 0);
        end
        6:    txn(r32[0], ~r32[0], {4'hF, 24'h0, 2'b01, r32[2:1]}, d32, 0);
        default: begin
          case (r32[5:4])
            2'd0:    txn(1, 0, {4'h3, r32[27:0]}, 0, 0);
            2'd1:    txn(0, 1, 32'hE000_0008, d32, 0);
            2'd2:    txn(1, 0, 32'hF000_000C, 0, 0);
            default: txn(1, 1, {4'h0, r32[27:0]}, d32, 0);
          endcase
        end
      endcase
      gap($urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
